// File: rtl/iq_ddc_mixer_pkg.sv
// Shared defaults, quadrant encoding and width helpers for the IQ down-conversion mixer.
package iq_ddc_mixer_pkg;

    localparam int DEF_DIN_W     = 10;
    localparam int DEF_LO_W      = 10;
    localparam int DEF_PHASE_W   = 16;
    localparam int DEF_LUT_AW    = 8;
    localparam int DEF_OUT_W     = 20;
    localparam int DEF_FREQ_INIT = 8192;

    // Top two LUT index bits select the quadrant of the LO phase.
    typedef enum logic [1:0] {
        QUAD_0   = 2'd0,
        QUAD_90  = 2'd1,
        QUAD_180 = 2'd2,
        QUAD_270 = 2'd3
    } quad_e;

    // Number of product LSBs removed by the round/saturate stage.
    function automatic int drop_bits(input int din_w, input int lo_w, input int out_w);
        return din_w + lo_w - out_w;
    endfunction

endpackage

// File: rtl/iq_ddc_mixer_if.sv
// Sample/control inputs and mixed I/Q outputs of the down-conversion mixer.
interface iq_ddc_mixer_if #(
    parameter int DIN_W   = iq_ddc_mixer_pkg::DEF_DIN_W,
    parameter int LO_W    = iq_ddc_mixer_pkg::DEF_LO_W,
    parameter int PHASE_W = iq_ddc_mixer_pkg::DEF_PHASE_W,
    parameter int OUT_W   = iq_ddc_mixer_pkg::DEF_OUT_W
) ();

    // Handshake: din_valid qualifies din for one cycle and has no ready; every
    // valid cycle is accepted. dout_valid likewise qualifies dout_i/dout_q/lo_sin
    // for one cycle with no backpressure; outputs hold while it is low.
    logic signed [DIN_W-1:0] din;
    logic                    din_valid;
    logic [PHASE_W-1:0]      freq_word;
    logic                    freq_wr;
    logic                    phase_clr;
    logic signed [OUT_W-1:0] dout_i;
    logic signed [OUT_W-1:0] dout_q;
    logic                    dout_valid;
    logic signed [LO_W-1:0]  lo_sin;

    modport master (
        output din, din_valid, freq_word, freq_wr, phase_clr,
        input  dout_i, dout_q, dout_valid, lo_sin
    );

    modport slave (
        input  din, din_valid, freq_word, freq_wr, phase_clr,
        output dout_i, dout_q, dout_valid, lo_sin
    );

endinterface

// File: rtl/iq_lut_qw.sv
// Quarter-wave sine magnitude ROM, 2^LUT_AW+1 entries, one-cycle registered read.
module iq_lut_qw
    import iq_ddc_mixer_pkg::*;
#(
    parameter int LO_W   = DEF_LO_W,
    parameter int LUT_AW = DEF_LUT_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LUT_AW:0]   addr,
    output logic [LO_W-1:0]   mag
);

    localparam int N = 1 << LUT_AW;

    function automatic logic [LO_W-1:0] entry(input int k);
        real amp;
        real x;
        amp = real'((1 << (LO_W - 1)) - 1);
        x   = amp * $sin(real'(k) * 3.14159265358979323846 / (2.0 * real'(N)));
        return LO_W'($rtoi(x + 0.5));
    endfunction

    logic [LO_W-1:0] rom [0:N];

    for (genvar k = 0; k <= N; k++) begin : g_rom
        assign rom[k] = entry(k);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag <= '0;
        end else begin
            mag <= rom[addr];
        end
    end

endmodule

// File: rtl/iq_ddc_mixer.sv
// Digital down-conversion mixer: NCO phase accumulator, quarter-wave LO and
// complex multiply with round/saturate, four-stage pipeline.
module iq_ddc_mixer
    import iq_ddc_mixer_pkg::*;
#(
    parameter int DIN_W     = DEF_DIN_W,
    parameter int LO_W      = DEF_LO_W,
    parameter int PHASE_W   = DEF_PHASE_W,
    parameter int LUT_AW    = DEF_LUT_AW,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int FREQ_INIT = DEF_FREQ_INIT
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    iq_ddc_mixer_if.slave  bus
);

    localparam int N     = 1 << LUT_AW;
    localparam int IDX_W = 2 + LUT_AW;
    localparam int PW    = DIN_W + LO_W;
    localparam int RD    = drop_bits(DIN_W, LO_W, OUT_W);

    localparam logic signed [PW:0] HALF    = (PW + 1)'((2 ** RD) / 2);
    localparam logic signed [PW:0] OUT_MAX = (PW + 1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [PW:0] OUT_MIN = ~OUT_MAX;

    function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [PW-1:0] p);
        logic signed [PW:0] sum;
        sum = {p[PW-1], p} + HALF;
        sum = sum >>> RD;
        if (sum > OUT_MAX) begin
            return OUT_MAX[OUT_W-1:0];
        end else if (sum < OUT_MIN) begin
            return OUT_MIN[OUT_W-1:0];
        end
        return sum[OUT_W-1:0];
    endfunction

    // Phase accumulator and frequency register. A sample's phase is the
    // accumulator value before its own increment; clear wins over increment.
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] freq_reg;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc      <= '0;
            freq_reg <= PHASE_W'(FREQ_INIT);
        end else begin
            if (bus.freq_wr) begin
                freq_reg <= bus.freq_word;
            end
            if (bus.phase_clr) begin
                acc <= '0;
            end else if (bus.din_valid) begin
                acc <= acc + freq_reg;
            end
        end
    end

    // S1: capture phase, fold into sine/cosine quarter-wave addresses.
    logic [IDX_W-1:0]  idx;
    logic [1:0]        quad_in;
    logic [LUT_AW:0]   fine_x;
    logic [LUT_AW:0]   mirror;

    assign idx     = acc[PHASE_W-1 -: IDX_W];
    assign quad_in = idx[IDX_W-1 -: 2];
    assign fine_x  = {1'b0, idx[LUT_AW-1:0]};
    assign mirror  = (LUT_AW + 1)'(N) - fine_x;

    logic                    s1_valid;
    logic signed [DIN_W-1:0] s1_din;
    quad_e                   s1_quad;
    logic [LUT_AW:0]         s1_sin_addr;
    logic [LUT_AW:0]         s1_cos_addr;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_valid    <= 1'b0;
            s1_din      <= '0;
            s1_quad     <= QUAD_0;
            s1_sin_addr <= '0;
            s1_cos_addr <= '0;
        end else begin
            s1_valid <= bus.din_valid;
            if (bus.din_valid) begin
                s1_din      <= bus.din;
                s1_quad     <= quad_e'(quad_in);
                s1_sin_addr <= quad_in[0] ? mirror : fine_x;
                s1_cos_addr <= quad_in[0] ? fine_x : mirror;
            end
        end
    end

    // S2: registered LUT reads; data alongside is delayed to match.
    logic [LO_W-1:0]         sin_mag;
    logic [LO_W-1:0]         cos_mag;
    logic                    s2_valid;
    logic signed [DIN_W-1:0] s2_din;
    quad_e                   s2_quad;

    iq_lut_qw #(.LO_W(LO_W), .LUT_AW(LUT_AW)) u_lut_sin (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .addr  (s1_sin_addr),
        .mag   (sin_mag)
    );

    iq_lut_qw #(.LO_W(LO_W), .LUT_AW(LUT_AW)) u_lut_cos (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .addr  (s1_cos_addr),
        .mag   (cos_mag)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s2_valid <= 1'b0;
            s2_din   <= '0;
            s2_quad  <= QUAD_0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_din  <= s1_din;
                s2_quad <= s1_quad;
            end
        end
    end

    // S3: restore signs from the quadrant, then full-precision products.
    logic signed [PW-1:0] mag_sin;
    logic signed [PW-1:0] mag_cos;
    logic signed [PW-1:0] sin_x;
    logic signed [PW-1:0] cos_x;
    logic signed [PW-1:0] din_x;

    always_comb begin
        mag_sin = PW'(sin_mag);
        mag_cos = PW'(cos_mag);
        din_x   = PW'(s2_din);
        sin_x   = mag_sin;
        cos_x   = mag_cos;
        case (s2_quad)
            QUAD_0:   begin end
            QUAD_90:  cos_x = -mag_cos;
            QUAD_180: begin
                sin_x = -mag_sin;
                cos_x = -mag_cos;
            end
            QUAD_270: sin_x = -mag_sin;
            default:  begin end
        endcase
    end

    logic                   s3_valid;
    logic signed [PW-1:0]   s3_prod_i;
    logic signed [PW-1:0]   s3_prod_q;
    logic signed [LO_W-1:0] s3_sin;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s3_valid  <= 1'b0;
            s3_prod_i <= '0;
            s3_prod_q <= '0;
            s3_sin    <= '0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_prod_i <= din_x * cos_x;
                s3_prod_q <= -(din_x * sin_x);
                s3_sin    <= sin_x[LO_W-1:0];
            end
        end
    end

    // S4: round/saturate into the output registers, which hold between samples.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bus.dout_valid <= 1'b0;
            bus.dout_i     <= '0;
            bus.dout_q     <= '0;
            bus.lo_sin     <= '0;
        end else begin
            bus.dout_valid <= s3_valid;
            if (s3_valid) begin
                bus.dout_i <= round_sat(s3_prod_i);
                bus.dout_q <= round_sat(s3_prod_q);
                bus.lo_sin <= s3_sin;
            end
        end
    end

endmodule

// File: tb/tb_iq_ddc_mixer.sv
// Bench for iq_ddc_mixer: full-precision and 16-bit-output instances driven in
// lockstep and checked against a trigonometric reference model.
module tb_iq_ddc_mixer;
    import iq_ddc_mixer_pkg::*;

    localparam int DIN_W   = 10;
    localparam int LO_W    = 10;
    localparam int PHASE_W = 16;
    localparam int LUT_AW  = 8;
    localparam int OUT_W   = 20;
    localparam int OUT_W16 = 16;
    localparam int AMP     = 511;
    localparam real PI     = 3.14159265358979323846;

    // ---------------- clock / reset ----------------
    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b1;

    always #5 sys_clk = ~sys_clk;

    iq_ddc_mixer_if #(.DIN_W(DIN_W), .LO_W(LO_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W))   bus ();
    iq_ddc_mixer_if #(.DIN_W(DIN_W), .LO_W(LO_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W16)) bus16 ();

    iq_ddc_mixer #(
        .DIN_W(DIN_W), .LO_W(LO_W), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW),
        .OUT_W(OUT_W), .FREQ_INIT(8192)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus.slave)
    );

    iq_ddc_mixer #(
        .DIN_W(DIN_W), .LO_W(LO_W), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW),
        .OUT_W(OUT_W16), .FREQ_INIT(8192)
    ) dut16 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus16.slave)
    );

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        longint i;
        longint q;
        longint i16;
        longint q16;
        longint s;
    } exp_t;

    exp_t exp_q[$];
    logic vq[$];
    exp_t last;
    int   m_acc;
    int   m_freq;
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic longint round_sym(input real x);
        if (x >= 0.0) return longint'($rtoi($floor(x + 0.5)));
        return -longint'($rtoi($floor(-x + 0.5)));
    endfunction

    // Round half-up over the 4 dropped LSBs, then clamp to 16-bit signed.
    function automatic longint round16(input longint x);
        longint y;
        y = longint'($rtoi($floor((real'(x) + 8.0) / 16.0)));
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    task automatic push_expected(input int d, input int phase);
        int   idx;
        real  th;
        exp_t e;
        idx   = phase / (1 << (PHASE_W - 2 - LUT_AW));
        th    = 2.0 * PI * real'(idx) / real'(1 << (2 + LUT_AW));
        e.s   = round_sym(real'(AMP) * $sin(th));
        e.i   = longint'(d) * round_sym(real'(AMP) * $cos(th));
        e.q   = -(longint'(d) * e.s);
        e.i16 = round16(e.i);
        e.q16 = round16(e.q);
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_acc  = 0;
        m_freq = 8192;
        vq.delete();
        exp_q.delete();
        last = '{i: 0, q: 0, i16: 0, q16: 0, s: 0};
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input int d, input logic fw, input int fword, input logic pc);
        bus.din         = DIN_W'(d);
        bus.din_valid   = v;
        bus.freq_word   = PHASE_W'(fword);
        bus.freq_wr     = fw;
        bus.phase_clr   = pc;
        bus16.din       = DIN_W'(d);
        bus16.din_valid = v;
        bus16.freq_word = PHASE_W'(fword);
        bus16.freq_wr   = fw;
        bus16.phase_clr = pc;
    endtask

    task automatic check_outputs(input logic exp_v);
        check("dout_valid", longint'(bus.dout_valid), longint'(exp_v));
        check("dout_valid16", longint'(bus16.dout_valid), longint'(exp_v));
        if (exp_v) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            end else begin
                last = exp_q.pop_front();
            end
        end
        check("dout_i", longint'(bus.dout_i), last.i);
        check("dout_q", longint'(bus.dout_q), last.q);
        check("lo_sin", longint'(bus.lo_sin), last.s);
        check("dout_i16", longint'(bus16.dout_i), last.i16);
        check("dout_q16", longint'(bus16.dout_q), last.q16);
        check("lo_sin16", longint'(bus16.lo_sin), last.s);
    endtask

    // One clock cycle: apply inputs, advance the model, check after the edge.
    task automatic step(input logic v, input int d, input logic fw, input int fword, input logic pc);
        logic exp_v;
        drive(v, d, fw, fword, pc);
        if (v) push_expected(d, m_acc);
        if (pc) m_acc = 0;
        else if (v) m_acc = (m_acc + m_freq) % (1 << PHASE_W);
        if (fw) m_freq = fword;
        vq.push_back(v);
        exp_v = 1'b0;
        if (vq.size() == 4) exp_v = vq.pop_front();
        @(posedge sys_clk);
        #1;
        check_outputs(exp_v);
    endtask

    task automatic pulse_reset();
        drive(1'b0, 0, 1'b0, 0, 1'b0);
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_dout_valid", longint'(bus.dout_valid), 0);
        check("rst_dout_i", longint'(bus.dout_i), 0);
        check("rst_dout_q", longint'(bus.dout_q), 0);
        check("rst_lo_sin", longint'(bus.lo_sin), 0);
        check("rst_dout_valid16", longint'(bus16.dout_valid), 0);
        check("rst_dout_q16", longint'(bus16.dout_q), 0);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        drive(1'b0, 0, 1'b0, 0, 1'b0);
        #3;
        pulse_reset();

        // Reset-default frequency, full-scale positive input held valid.
        for (int k = 0; k < 20; k++) step(1'b1, 511, 1'b0, 0, 1'b0);

        // Frequency change coincident with a sample.
        for (int k = 0; k < 3; k++) step(1'b1, $urandom_range(0, 1023) - 512, 1'b0, 0, 1'b0);
        step(1'b1, 300, 1'b1, 16384, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b1, $urandom_range(0, 1023) - 512, 1'b0, 0, 1'b0);

        // Sparse valids, one in three, back at the default frequency from phase 0.
        step(1'b0, 0, 1'b1, 8192, 1'b1);
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 511, 1'b0, 0, 1'b0);
            idle(2);
        end

        // Clear and frequency load together, coincident with a sample.
        step(1'b1, $urandom_range(0, 1023) - 512, 1'b1, 4096, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b1, $urandom_range(0, 1023) - 512, 1'b0, 0, 1'b0);

        // Extremes at the cardinal angles for both full-scale input polarities.
        step(1'b0, 0, 1'b1, 16384, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, -512, 1'b0, 0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 511, 1'b0, 0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, -512, 1'b0, 0, 1'b0);
        idle(5);

        // Randomized traffic with occasional frequency loads and clears.
        for (int k = 0; k < 300; k++) begin
            step(logic'($urandom_range(0, 1)),
                 $urandom_range(0, 1023) - 512,
                 logic'($urandom_range(0, 15) == 0),
                 $urandom_range(0, 65535),
                 logic'($urandom_range(0, 19) == 0));
        end

        // Reset with three samples in flight; nothing may emerge afterwards.
        for (int k = 0; k < 3; k++) step(1'b1, $urandom_range(0, 1023) - 512, 1'b0, 0, 1'b0);
        #2;
        pulse_reset();
        idle(6);
        step(1'b1, 400, 1'b0, 0, 1'b0);
        step(1'b1, -200, 1'b0, 0, 1'b0);
        idle(6);

        check("scoreboard_drained", longint'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
